// File: rtl/alu_pkg.sv
// Shared ALU types for the tinyalu driver and its command FIFO.
// The ALU operand, result and opcode types live here so the driver, FIFO and any ALU model agree on widths.
package alu_pkg;

    typedef logic [7:0]  operand_t;
    typedef logic [15:0] result_t;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        AND = 3'd2,
        XOR = 3'd3,
        MUL = 3'd4,
        SUB = 3'd5,
        NOT = 3'd6,
        INC = 3'd7
    } opcode_t;

    // One buffered request: opcode + A + B, 19 bits.
    typedef struct packed {
        opcode_t  opcode;
        operand_t a;
        operand_t b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic cmd_t pack_cmd(input opcode_t op, input operand_t a, input operand_t b);
        cmd_t c;
        c.opcode = op;
        c.a      = a;
        c.b      = b;
        return c;
    endfunction

endpackage

// File: rtl/tinyalu_driver_if.sv
// Request, ALU and response handshake bundle for the tinyalu driver.
// "master" is the driver's view; "slave" is the sequencer/ALU/consumer side.
interface tinyalu_driver_if;
    import alu_pkg::*;

    logic     cmd_valid;
    logic     cmd_ready;
    opcode_t  cmd_opcode;
    operand_t cmd_a;
    operand_t cmd_b;

    logic     alu_start;
    opcode_t  alu_opcode;
    operand_t alu_a;
    operand_t alu_b;
    logic     alu_done;
    result_t  alu_result;

    logic     rsp_valid;
    logic     rsp_ready;
    result_t  rsp_result;
    opcode_t  rsp_opcode;
    logic     rsp_timeout;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
        output cmd_ready, alu_start, alu_opcode, alu_a, alu_b,
               rsp_valid, rsp_result, rsp_opcode, rsp_timeout
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
        input  cmd_ready, alu_start, alu_opcode, alu_a, alu_b,
               rsp_valid, rsp_result, rsp_opcode, rsp_timeout
    );
endinterface

// File: rtl/tinyalu_driver_cmd_fifo.sv
// Synchronous command FIFO for the tinyalu driver; flop-based storage,
// the head entry is read straight from the register array.
module driver_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r[AW-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

endmodule

// File: rtl/tinyalu_driver.sv
// Command-side initiator for the ALU start/done handshake: buffers requests,
// issues them one at a time, and returns each result (or timeout) in order.
module tinyalu_driver
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    tinyalu_driver_if.master   bus,
    output logic               busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;
    cmd_t             head_s;

    logic     alu_start_r;
    opcode_t  alu_opcode_r;
    operand_t alu_a_r;
    operand_t alu_b_r;
    logic     rsp_valid_r;
    result_t  rsp_result_r;
    opcode_t  rsp_opcode_r;
    logic     rsp_timeout_r;

    assign bus.cmd_ready = !fifo_full_s && !reset;
    assign push_s        = bus.cmd_valid && bus.cmd_ready;
    // A late done from an aborted command must not be mistaken for the next one's.
    assign pop_s         = (state_r == IDLE) && !fifo_empty_s && !bus.alu_done;

    driver_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (pack_cmd(bus.cmd_opcode, bus.cmd_a, bus.cmd_b)),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Issue/response sequencer with a bounded wait for done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            alu_start_r   <= 1'b0;
            alu_opcode_r  <= NOP;
            alu_a_r       <= 8'h00;
            alu_b_r       <= 8'h00;
            rsp_valid_r   <= 1'b0;
            rsp_result_r  <= 16'h0000;
            rsp_opcode_r  <= NOP;
            rsp_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        alu_opcode_r <= head_s.opcode;
                        alu_a_r      <= head_s.a;
                        alu_b_r      <= head_s.b;
                        alu_start_r  <= 1'b1;
                        cnt_r        <= '0;
                        state_r      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.alu_done) begin
                        rsp_result_r  <= (alu_opcode_r == NOP) ? 16'h0000 : bus.alu_result;
                        rsp_opcode_r  <= alu_opcode_r;
                        rsp_timeout_r <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        alu_start_r   <= 1'b0;
                        state_r       <= RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        rsp_result_r  <= 16'h0000;
                        rsp_opcode_r  <= alu_opcode_r;
                        rsp_timeout_r <= 1'b1;
                        rsp_valid_r   <= 1'b1;
                        alu_start_r   <= 1'b0;
                        state_r       <= RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    alu_start_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_start   = alu_start_r;
    assign bus.alu_opcode  = alu_opcode_r;
    assign bus.alu_a       = alu_a_r;
    assign bus.alu_b       = alu_b_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_result  = rsp_result_r;
    assign bus.rsp_opcode  = rsp_opcode_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign busy            = !fifo_empty_s || (state_r != IDLE);

endmodule
